word_window_buffer: RTL and testbench
=====================================

WORD_WINDOW_BUFFER -- requirements
Module: word_window_buffer

Interface
REQ-001 Parameter WORD_WIDTH, 32, bits per stored word.
REQ-002 Parameter DEPTH, 19, word capacity, legal range 2..31.
REQ-003 Parameter NUM_PORTS, 4, independent indexed read ports, legal range 1..8.
REQ-004 Parameter OVERWRITE, 0, full-buffer policy: 0 = stall push, 1 = evict oldest word.
REQ-005 Derived widths: IDX_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
REQ-006 Timing: one clock; reset is synchronous and active-high.
REQ-007 Port list, one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- word_in  in  WORD_WIDTH  push data.
- word_valid  in  1  push request.
- word_accepted  out  1  push taken this cycle (combinational).
- clear  in  1  empty the buffer.
- drop_cnt  in  CNT_W  oldest words to discard.
- drop_valid  in  1  drop request.
- rd_req  in  1  read request; samples all read-port inputs.
- rd_idx  in  NUM_PORTS*IDX_W  per-port index; 0 = oldest word.
- rd_en  in  NUM_PORTS  per-port enable.
- rd_data  out  NUM_PORTS*WORD_WIDTH  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- rd_oob  out  NUM_PORTS  per-port index-out-of-range flag, registered with rd_data.
- current_size  out  CNT_W  stored word count.
- full  out  1  current_size == DEPTH.
- ready  out  1  buffer can take a push this cycle.
- overflow  out  1  one-cycle pulse when an OVERWRITE eviction occurs.

Function
REQ-008 Storage is a circular buffer with head (oldest) and tail pointers; both wrap from DEPTH-1 to 0 without skipping a slot.
REQ-009 ready = !clear && (!full || OVERWRITE); word_accepted = word_valid && ready.
REQ-010 A push writes word_in at tail and advances tail; if full and OVERWRITE=1, head also advances, size holds and overflow pulses the following cycle.
REQ-011 A drop advances head by min(drop_cnt, current_size); drop_cnt = 0 is a no-op.
REQ-012 Same-cycle push and drop: the drop applies to the pre-push contents; size_next = size - dropped + 1, and no overflow occurs because the drop frees space first.
REQ-013 clear has priority over push and drop: head = tail = 0, size = 0, and any same-cycle push is ignored (word_accepted = 0).
REQ-014 Read latency is exactly 1 cycle: rd_req in cycle N -> rd_data/rd_oob/rd_valid in cycle N+1; rd_valid is a single-cycle pulse per request.
REQ-015 Reads observe the contents at the start of cycle N, before any same-cycle push, drop or clear.
REQ-016 Per port p: if rd_en[p]=0, data = 0 and oob = 0; if rd_idx[p] >= current_size, data = 0 and oob = 1; otherwise data = mem[(head + rd_idx[p]) mod DEPTH].
REQ-017 rd_data and rd_oob hold their values until the next rd_req completes; back-to-back rd_req every cycle is supported at full throughput.
REQ-018 current_size never exceeds DEPTH and never underflows.

Reset
REQ-019 On rst in any cycle: head = tail = 0, current_size = 0, rd_data = 0, rd_oob = 0, rd_valid = 0, overflow = 0; pending reads and pushes are discarded.
REQ-020 Storage array contents are not reset; they are unreachable until rewritten.
REQ-021 During rst: word_accepted = 0 and ready = 0; in the first cycle after rst, ready = 1.

Structure
REQ-022 Derived-width functions (clog2) and the OVERWRITE mode constants live in the shared package wwb_pkg.
REQ-023 One sub-module, wwb_read_port: a single registered indexed read with enable/oob logic, instantiated NUM_PORTS times via generate.

Verification
REQ-024 Fill/wrap: DEPTH=19, OVERWRITE=0, push 0x00..0x16 back-to-back -> first 19 accepted, size = 19, full = 1, last 4 pushes rejected; a read with idx 0/18 returns 0x00/0x12.
REQ-025 Overwrite: OVERWRITE=1, push 23 words w0..w22 -> overflow pulses 4 times, size = 19, read idx 0 = w4, idx 18 = w22.
REQ-026 Mask/oob: size = 5, read with idx {3,4,7,0} and rd_en = 4'b1011 -> port0 = mem[3], port1 = mem[4], port2 = 0 with oob = 0, port3 = mem[0]; idx 7 on an enabled port -> oob = 1, data = 0.
REQ-027 Simultaneous events: when full, push + drop_cnt = 3 in one cycle -> size = 17, no overflow; the same cycle's read returns pre-update data.
REQ-028 Clear priority: clear + push + drop in one cycle -> size = 0 next cycle, word_accepted = 0; a following read of idx 0 -> oob = 1.
REQ-029 Reset mid-operation: assert rst while rd_req is high and the buffer is half full -> rd_valid = 0, size = 0 next cycle, ready = 1 one cycle after rst deasserts.

Source files
------------

// File: rtl/wwb_pkg.sv
// Shared definitions for the word window buffer: full-buffer policy
// constants and the width helper used to size pointers and counters.
package wwb_pkg;

    // Full-buffer push policy.
    localparam int OVERWRITE_STALL = 0;  // reject pushes while full
    localparam int OVERWRITE_EVICT = 1;  // drop the oldest word to make room

    // Ceiling log2; used at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wwb_read_port.sv
// One registered indexed read port of the word window buffer. The index is
// relative to the oldest word; the port turns it into a physical slot and
// registers the word (or zero with an out-of-range flag) for one-cycle latency.
module wwb_read_port #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 19,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_i,
    input  logic                  rd_en_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    input  logic [IDX_W-1:0]      head_i,
    input  logic [CNT_W-1:0]      size_i,
    output logic [IDX_W-1:0]      addr_o,
    input  logic [WORD_WIDTH-1:0] word_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  oob_o
);

    // Wide enough for head + index without losing the carry.
    localparam int SUM_W = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 1;

    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      wrapped;
    logic                  in_range;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  oob_q, oob_d;

    // Resolve the slot address and pick the next registered result.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        in_range = SUM_W'(rd_idx_i) < SUM_W'(size_i);
        sum      = SUM_W'(head_i) + SUM_W'(rd_idx_i);
        wrapped  = (sum >= SUM_W'(DEPTH)) ? sum - SUM_W'(DEPTH) : sum;
        // Park the address on slot 0 when the index is unusable so it never leaves the array.
        addr_o   = in_range ? IDX_W'(wrapped) : '0;
        data_d   = data_q;
        oob_d    = oob_q;
        if (rd_req_i) begin
            if (!rd_en_i) begin
                data_d = '0;
                oob_d  = 1'b0;
            end else if (!in_range) begin
                data_d = '0;
                oob_d  = 1'b1;
            end else begin
                data_d = word_i;
                oob_d  = 1'b0;
            end
        end
    end

    // Result register: updated only by a request, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            oob_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            oob_q  <= oob_d;
        end
    end

    assign data_o = data_q;
    assign oob_o  = oob_q;

endmodule

// File: rtl/word_window_buffer.sv
// Word window buffer: a circular word store that accepts pushes at the tail,
// discards from the head in bulk, and serves NUM_PORTS indexed reads relative
// to the oldest word with one cycle of latency.
module word_window_buffer
    import wwb_pkg::*;
#(
    parameter  int WORD_WIDTH = 32,
    parameter  int DEPTH      = 19,
    parameter  int NUM_PORTS  = 4,
    parameter  int OVERWRITE  = OVERWRITE_STALL,
    localparam int IDX_W      = clog2(DEPTH),
    localparam int CNT_W      = clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORD_WIDTH-1:0]           word_in,
    input  logic                            word_valid,
    output logic                            word_accepted,
    input  logic                            clear,
    input  logic [CNT_W-1:0]                drop_cnt,
    input  logic                            drop_valid,
    input  logic                            rd_req,
    input  logic [NUM_PORTS*IDX_W-1:0]      rd_idx,
    input  logic [NUM_PORTS-1:0]            rd_en,
    output logic [NUM_PORTS*WORD_WIDTH-1:0] rd_data,
    output logic                            rd_valid,
    output logic [NUM_PORTS-1:0]            rd_oob,
    output logic [CNT_W-1:0]                current_size,
    output logic                            full,
    output logic                            ready,
    output logic                            overflow
);

    localparam int SUM_W      = CNT_W + 1;
    localparam bit EVICT_MODE = (OVERWRITE == OVERWRITE_EVICT);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      head_q, head_d;
    logic [IDX_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      size_q, size_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q;
    logic [CNT_W-1:0]      dropped;
    logic                  evict;
    logic [SUM_W-1:0]      head_sum;
    logic [SUM_W-1:0]      head_wrap;

    // Advance a pointer by one slot, wrapping from the last slot to zero.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
        return (ptr == IDX_W'(DEPTH - 1)) ? '0 : ptr + IDX_W'(1);
    endfunction

    assign full          = (size_q == CNT_W'(DEPTH));
    assign ready         = !rst && !clear && (!full || EVICT_MODE);
    assign word_accepted = word_valid && ready;

    // Next pointer/size state: drop first, then push (evicting only if still full), clear overrides all.
    always_comb begin
        dropped = '0;
        if (drop_valid) begin
            dropped = (drop_cnt < size_q) ? drop_cnt : size_q;
        end
        // A drop of at least one word always makes room, so eviction needs a zero drop.
        evict      = word_accepted && full && (dropped == '0);
        head_sum   = SUM_W'(head_q) + SUM_W'(dropped);
        head_wrap  = (head_sum >= SUM_W'(DEPTH)) ? head_sum - SUM_W'(DEPTH) : head_sum;
        head_d     = evict ? ptr_inc(head_q) : IDX_W'(head_wrap);
        tail_d     = word_accepted ? ptr_inc(tail_q) : tail_q;
        size_d     = size_q - dropped + ((word_accepted && !evict) ? CNT_W'(1) : CNT_W'(0));
        overflow_d = evict;
        if (clear) begin
            head_d     = '0;
            tail_d     = '0;
            size_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            size_q     <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            size_q     <= size_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_req;
        end
    end

    // Word storage write at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; slots outside head..tail are never observable.
        if (word_accepted) begin
            mem_q[tail_q] <= word_in;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [IDX_W-1:0] addr;

        wwb_read_port #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (DEPTH),
            .IDX_W      (IDX_W),
            .CNT_W      (CNT_W)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .rd_req_i (rd_req),
            .rd_en_i  (rd_en[p]),
            .rd_idx_i (rd_idx[p*IDX_W +: IDX_W]),
            .head_i   (head_q),
            .size_i   (size_q),
            .addr_o   (addr),
            .word_i   (mem_q[addr]),
            .data_o   (rd_data[p*WORD_WIDTH +: WORD_WIDTH]),
            .oob_o    (rd_oob[p])
        );
    end

    assign current_size = size_q;
    assign overflow     = overflow_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_word_window_buffer.sv
// Bench for word_window_buffer: one stall-mode and one evict-mode instance
// driven side by side against a shift-array reference model.
module tb_word_window_buffer;

    localparam int DEPTH = 19;
    localparam int NP    = 4;
    localparam int WW    = 32;
    localparam int IW    = 5;
    localparam int CW    = 5;

    typedef struct {
        int              d;
        bit              vld;
        logic [NP*WW-1:0] data;
        logic [NP-1:0]   oob;
    } exp_t;

    typedef struct {
        logic [NP-1:0][IW-1:0] idx;
        logic [NP-1:0]         en;
        logic [NP-1:0][WW-1:0] data;
        logic [NP-1:0]         oob;
    } vec_t;

    logic             clk;
    logic             rst          [2];
    logic [WW-1:0]    word_in      [2];
    logic             word_valid   [2];
    logic             word_accepted[2];
    logic             clear        [2];
    logic [CW-1:0]    drop_cnt     [2];
    logic             drop_valid   [2];
    logic             rd_req       [2];
    logic [NP*IW-1:0] rd_idx       [2];
    logic [NP-1:0]    rd_en        [2];
    logic [NP*WW-1:0] rd_data      [2];
    logic             rd_valid     [2];
    logic [NP-1:0]    rd_oob       [2];
    logic [CW-1:0]    current_size [2];
    logic             full         [2];
    logic             ready        [2];
    logic             overflow     [2];

    // Reference model: oldest word at index 0.
    logic [WW-1:0]    mw [2][DEPTH];
    int               msz[2];
    bit               mov[2];
    logic [NP*WW-1:0] last_data[2];
    logic [NP-1:0]    last_oob [2];
    exp_t             sb[$];
    vec_t             tbl[5];

    int checks;
    int errors;
    int ov_seen;

    word_window_buffer #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .NUM_PORTS(NP), .OVERWRITE(0)) u_stall (
        .clk(clk), .rst(rst[0]), .word_in(word_in[0]), .word_valid(word_valid[0]),
        .word_accepted(word_accepted[0]), .clear(clear[0]), .drop_cnt(drop_cnt[0]),
        .drop_valid(drop_valid[0]), .rd_req(rd_req[0]), .rd_idx(rd_idx[0]), .rd_en(rd_en[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_oob(rd_oob[0]),
        .current_size(current_size[0]), .full(full[0]), .ready(ready[0]), .overflow(overflow[0])
    );

    word_window_buffer #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .NUM_PORTS(NP), .OVERWRITE(1)) u_evict (
        .clk(clk), .rst(rst[1]), .word_in(word_in[1]), .word_valid(word_valid[1]),
        .word_accepted(word_accepted[1]), .clear(clear[1]), .drop_cnt(drop_cnt[1]),
        .drop_valid(drop_valid[1]), .rd_req(rd_req[1]), .rd_idx(rd_idx[1]), .rd_en(rd_en[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_oob(rd_oob[1]),
        .current_size(current_size[1]), .full(full[1]), .ready(ready[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [NP*WW-1:0] act, input logic [NP*WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int d);
        rst[d]        = 1'b0;
        word_in[d]    = '0;
        word_valid[d] = 1'b0;
        clear[d]      = 1'b0;
        drop_cnt[d]   = '0;
        drop_valid[d] = 1'b0;
        rd_req[d]     = 1'b0;
        rd_idx[d]     = '0;
        rd_en[d]      = '0;
    endtask

    task automatic model_shift(input int d, input int n);
        for (int i = 0; i + n < msz[d]; i++) mw[d][i] = mw[d][i + n];
        msz[d] -= n;
    endtask

    // One clock: check combinational outputs, record read expectations,
    // advance the model, then check state and pop the scoreboard.
    task automatic tick();
        bit   exp_rdy[2];
        bit   acc[2];
        bit   seen[2];
        exp_t e;
        int   idx;
        int   n;
        bit   ev;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rdy[d] = !rst[d] && !clear[d] && (msz[d] < DEPTH || d == 1);
            acc[d]     = word_valid[d] && exp_rdy[d];
            check($sformatf("ready[%0d]", d), ready[d], exp_rdy[d]);
            check($sformatf("accepted[%0d]", d), word_accepted[d], acc[d]);
            if (!rst[d]) check($sformatf("full[%0d]", d), full[d], msz[d] == DEPTH);
            e.d = d; e.vld = 1'b0; e.data = '0; e.oob = '0;
            if (rst[d]) begin
                sb.push_back(e);
            end else if (rd_req[d]) begin
                e.vld = 1'b1;
                for (int p = 0; p < NP; p++) begin
                    idx = int'(rd_idx[d][p*IW +: IW]);
                    if (!rd_en[d][p]) begin
                        e.data[p*WW +: WW] = '0;
                    end else if (idx >= msz[d]) begin
                        e.oob[p] = 1'b1;
                    end else begin
                        e.data[p*WW +: WW] = mw[d][idx];
                    end
                end
                sb.push_back(e);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            ev = 1'b0;
            if (rst[d] || clear[d]) begin
                msz[d] = 0;
            end else begin
                n = drop_valid[d] ? ((int'(drop_cnt[d]) < msz[d]) ? int'(drop_cnt[d]) : msz[d]) : 0;
                model_shift(d, n);
                if (acc[d]) begin
                    if (msz[d] == DEPTH) begin
                        model_shift(d, 1);
                        ev = 1'b1;
                    end
                    mw[d][msz[d]] = word_in[d];
                    msz[d]++;
                end
            end
            mov[d] = ev;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            seen[d] = 1'b0;
            check($sformatf("size[%0d]", d), current_size[d], msz[d]);
            check($sformatf("overflow[%0d]", d), overflow[d], mov[d]);
        end
        if (overflow[1] === 1'b1) ov_seen++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            seen[e.d] = 1'b1;
            check($sformatf("rd_valid[%0d]", e.d), rd_valid[e.d], e.vld);
            check($sformatf("rd_data[%0d]", e.d), rd_data[e.d], e.data);
            check($sformatf("rd_oob[%0d]", e.d), rd_oob[e.d], e.oob);
            last_data[e.d] = e.data;
            last_oob[e.d]  = e.oob;
        end
        for (int d = 0; d < 2; d++) begin
            if (!seen[d]) begin
                check($sformatf("rd_valid_idle[%0d]", d), rd_valid[d], 1'b0);
                check($sformatf("rd_data_hold[%0d]", d), rd_data[d], last_data[d]);
                check($sformatf("rd_oob_hold[%0d]", d), rd_oob[d], last_oob[d]);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; ov_seen = 0;
        msz = '{0, 0};
        mov = '{1'b0, 1'b0};

        // Mask/oob vectors against contents A0..A4 (index 0 oldest).
        tbl[0] = '{idx: {5'd0, 5'd7, 5'd4, 5'd3}, en: 4'b1011,
                   data: {32'hA0, 32'h0, 32'hA4, 32'hA3}, oob: 4'b0000};
        tbl[1] = '{idx: {5'd0, 5'd7, 5'd4, 5'd3}, en: 4'b1111,
                   data: {32'hA0, 32'h0, 32'hA4, 32'hA3}, oob: 4'b0100};
        tbl[2] = '{idx: {5'd5, 5'd2, 5'd1, 5'd0}, en: 4'b1111,
                   data: {32'h0, 32'hA2, 32'hA1, 32'hA0}, oob: 4'b1000};
        tbl[3] = '{idx: {5'd0, 5'd4, 5'd4, 5'd31}, en: 4'b0001,
                   data: {32'h0, 32'h0, 32'h0, 32'h0}, oob: 4'b0001};
        tbl[4] = '{idx: {5'd4, 5'd3, 5'd2, 5'd1}, en: 4'b1111,
                   data: {32'hA4, 32'hA3, 32'hA2, 32'hA1}, oob: 4'b0000};

        // Reset with a read pending on both instances.
        idle(0); idle(1);
        rst[0] = 1'b1; rst[1] = 1'b1; rd_req[0] = 1'b1; rd_req[1] = 1'b1;
        tick(); tick();
        idle(0); idle(1);
        tick();
        check("reset size", current_size[0], 0);

        // Fill past capacity: stall rejects the last 4, evict drops 4 oldest.
        ov_seen = 0;
        for (int i = 0; i < 23; i++) begin
            word_valid[0] = 1'b1; word_in[0] = WW'(i);
            word_valid[1] = 1'b1; word_in[1] = WW'(32'h100 + i);
            tick();
        end
        idle(0); idle(1);
        tick();
        check("overflow pulses", ov_seen, 4);
        check("fill size stall", current_size[0], 19);
        check("fill full stall", full[0], 1'b1);
        check("fill size evict", current_size[1], 19);

        for (int d = 0; d < 2; d++) begin
            rd_req[d] = 1'b1; rd_en[d] = 4'b1111;
            rd_idx[d] = {5'd19, 5'd5, 5'd18, 5'd0};
        end
        tick();
        idle(0); idle(1);
        check("fill idx0 stall", rd_data[0][31:0], 32'h00);
        check("fill idx18 stall", rd_data[0][63:32], 32'h12);
        check("fill idx19 oob", rd_oob[0], 4'b1000);
        check("evict idx0", rd_data[1][31:0], 32'h104);
        check("evict idx18", rd_data[1][63:32], 32'h116);

        // Full buffer, push + drop 3 + read in one cycle.
        for (int d = 0; d < 2; d++) begin
            word_valid[d] = 1'b1; word_in[d] = 32'hBEEF;
            drop_valid[d] = 1'b1; drop_cnt[d] = 5'd3;
            rd_req[d] = 1'b1; rd_en[d] = 4'b1111;
            rd_idx[d] = {5'd18, 5'd2, 5'd1, 5'd0};
        end
        tick();
        idle(0); idle(1);
        check("simul size evict", current_size[1], 17);
        check("simul no overflow", overflow[1], 1'b0);
        check("simul pre-data", rd_data[1][31:0], 32'h104);
        check("simul size stall", current_size[0], 16);

        // Drop boundaries on the stall instance.
        drop_valid[0] = 1'b1; drop_cnt[0] = 5'd0;
        tick();
        check("drop zero", current_size[0], 16);
        drop_cnt[0] = 5'd31;
        tick();
        check("drop excess", current_size[0], 0);
        drop_cnt[0] = 5'd5;
        tick();
        check("drop empty", current_size[0], 0);
        idle(0);

        // Table of masked / out-of-range reads against five words.
        for (int i = 0; i < 5; i++) begin
            word_valid[0] = 1'b1; word_in[0] = WW'(32'hA0 + i);
            tick();
        end
        idle(0);
        for (int i = 0; i < 5; i++) begin
            rd_req[0] = 1'b1; rd_idx[0] = tbl[i].idx; rd_en[0] = tbl[i].en;
            tick();
            check($sformatf("tbl%0d data", i), rd_data[0], tbl[i].data);
            check($sformatf("tbl%0d oob", i), rd_oob[0], tbl[i].oob);
        end
        idle(0);

        // Clear beats push and drop.
        clear[1] = 1'b1; word_valid[1] = 1'b1; word_in[1] = 32'h55;
        drop_valid[1] = 1'b1; drop_cnt[1] = 5'd2;
        #1;
        check("clear blocks push", word_accepted[1], 1'b0);
        tick();
        idle(1);
        check("clear size", current_size[1], 0);
        rd_req[1] = 1'b1; rd_en[1] = 4'b0001; rd_idx[1] = '0;
        tick();
        idle(1);
        check("clear idx0 oob", rd_oob[1][0], 1'b1);

        // Random traffic on both instances (exercises pointer wrap).
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                word_valid[d] = ($urandom_range(0, 2) != 0);
                word_in[d]    = WW'($urandom);
                drop_valid[d] = ($urandom_range(0, 3) == 0);
                drop_cnt[d]   = CW'($urandom_range(0, 7));
                clear[d]      = ($urandom_range(0, 59) == 0);
                rd_req[d]     = ($urandom_range(0, 1) == 1);
                rd_en[d]      = NP'($urandom);
                for (int p = 0; p < NP; p++) rd_idx[d][p*IW +: IW] = IW'($urandom_range(0, 20));
            end
            tick();
        end
        idle(0); idle(1);
        tick();

        // Reset mid-operation with a half-full buffer and a read pending.
        clear[0] = 1'b1;
        tick();
        idle(0);
        for (int i = 0; i < 10; i++) begin
            word_valid[0] = 1'b1; word_in[0] = WW'(32'hC0 + i);
            tick();
        end
        rst[0] = 1'b1; rd_req[0] = 1'b1; rd_en[0] = 4'b1111;
        tick();
        check("rst rd_valid", rd_valid[0], 1'b0);
        check("rst size", current_size[0], 0);
        idle(0);
        #1;
        check("ready after rst", ready[0], 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
